instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the byte-addressed instruction memory and downstream-facing to decode. Owns the program counter, drives the memory's combinational read address, and captures each returned 32-bit little-endian word with its PC into a small FIFO. Decode consumes entries through a valid/ready handshake. A branch/jump redirect flushes the FIFO and reloads the PC.

---
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally and
// buffers {pc, instr} pairs in a small FIFO for decode. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    output logic [31:0] O_imem_address,
    input  logic [31:0] I_imem_data,
    input  logic        I_halt,
    input  logic        I_redirect,
    input  logic [31:0] I_redirect_target,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [31:0] O_instr,
    output logic [31:0] O_pc,
    output logic        O_misaligned
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(BUF_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   entryPc_q    [BUF_DEPTH];
    logic [31:0]   entryInstr_q [BUF_DEPTH];

    logic valid;
    logic pop;
    logic full;
    logic fetch;

    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_COUNT);
    assign pop   = valid & I_ready;
    assign fetch = ~I_halt & ~I_redirect & (~full | pop);

    assign O_imem_address = pc_q;
    assign O_valid        = valid;
    assign O_instr        = valid ? entryInstr_q[rdPtr_q] : NOP_INSTR;
    assign O_pc           = valid ? entryPc_q[rdPtr_q]    : 32'h0000_0000;

    // A redirect wins over fetch and pop alike: the FIFO flushes and a same-cycle pop is void.
    always_comb begin
        pc_d    = pc_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (I_redirect) begin
            pc_d    = I_redirect_target & 32'hFFFF_FFFC;
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (fetch) begin
                pc_d    = pc_q + 32'd4;
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            count_d = count_q + CW'(fetch) - CW'(pop);
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            pc_q    <= RESET_PC;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; count gates visibility of stale slots.
    always_ff @(posedge I_clk) begin
        if (fetch) begin
            entryPc_q[wrPtr_q]    <= pc_q;
            entryInstr_q[wrPtr_q] <= I_imem_data;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= I_redirect & (I_redirect_target[1:0] != 2'b00);
        end
    end

    assign O_misaligned = misaligned_q;
`else
    assign O_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a queue-based reference model predicts every
// accepted {pc, instr} and a separate monitor compares them as decode accepts entries.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic [31:0] O_imem_address;
    logic [31:0] I_imem_data;
    logic        I_halt = 1'b0;
    logic        I_redirect = 1'b0;
    logic [31:0] I_redirect_target = 32'h0;
    logic        O_valid;
    logic        I_ready = 1'b0;
    logic [31:0] O_instr;
    logic [31:0] O_pc;
    logic        O_misaligned;

    int total = 0;
    int bad   = 0;

    // Reference model state: the FIFO as a plain queue plus the architectural PC.
    entry_t      modelQ[$];
    entry_t      expQ[$];
    logic [31:0] modelPc   = RESET_PC;
    logic        lastMis   = 1'b0;
    logic [31:0] addrExp   = RESET_PC;
    logic        validExp  = 1'b0;
    logic        misExp    = 1'b0;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .I_clk            (I_clk),
        .I_rst            (I_rst),
        .O_imem_address   (O_imem_address),
        .I_imem_data      (I_imem_data),
        .I_halt           (I_halt),
        .I_redirect       (I_redirect),
        .I_redirect_target(I_redirect_target),
        .O_valid          (O_valid),
        .I_ready          (I_ready),
        .O_instr          (O_instr),
        .O_pc             (O_pc),
        .O_misaligned     (O_misaligned)
    );

    always #5 I_clk = ~I_clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h0000_0013;
    endfunction

    assign I_imem_data = memWord(O_imem_address);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step: predicts what the coming rising edge does, from the inputs just driven.
    always @(negedge I_clk) begin
        #1;
        if (!I_rst) begin
            logic popNow;
            logic fullNow;
            addrExp  = modelPc;
            validExp = (modelQ.size() != 0);
            misExp   = lastMis;
            popNow   = validExp && I_ready;
            fullNow  = (modelQ.size() == BUF_DEPTH);
            if (I_redirect) begin
                modelQ.delete();
                modelPc = {I_redirect_target[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
                lastMis = (I_redirect_target[1:0] != 2'b00);
`else
                lastMis = 1'b0;
`endif
            end else begin
                if (popNow) expQ.push_back(modelQ.pop_front());
                if (!I_halt && (!fullNow || popNow)) begin
                    modelQ.push_back('{pc: modelPc, instr: memWord(modelPc)});
                    modelPc = modelPc + 32'd4;
                end
                lastMis = 1'b0;
            end
        end
    end

    // Monitor: checks the interface each cycle and pops the scoreboard on every real handshake.
    always @(negedge I_clk) begin
        #2;
        if (!I_rst) begin
            checkOutput("imem_address", O_imem_address, addrExp);
            checkOutput("valid", {31'b0, O_valid}, {31'b0, validExp});
            checkOutput("misaligned", {31'b0, O_misaligned}, {31'b0, misExp});
            if (!O_valid) begin
                checkOutput("idle_instr", O_instr, NOP_INSTR);
                checkOutput("idle_pc", O_pc, 32'h0);
            end
            if (O_valid && I_ready && !I_redirect) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    entry_t e;
                    e = expQ.pop_front();
                    checkOutput("head_pc", O_pc, e.pc);
                    checkOutput("head_instr", O_instr, e.instr);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rdy, input logic hlt, input logic rdr,
                                 input logic [31:0] tgt);
        @(negedge I_clk);
        I_rst             = 1'b0;
        I_ready           = rdy;
        I_halt            = hlt;
        I_redirect        = rdr;
        I_redirect_target = tgt;
    endtask

    task automatic checkResetState();
        checkOutput("rst_valid", {31'b0, O_valid}, 32'd0);
        checkOutput("rst_instr", O_instr, NOP_INSTR);
        checkOutput("rst_pc", O_pc, 32'h0);
        checkOutput("rst_misaligned", {31'b0, O_misaligned}, 32'd0);
        checkOutput("rst_address", O_imem_address, RESET_PC);
    endtask

    // Asserts reset in the middle of a cycle, away from any edge.
    task automatic doReset();
        @(negedge I_clk);
        #4;
        I_rst = 1'b1;
        #1;
        checkResetState();
        modelQ.delete();
        expQ.delete();
        modelPc = RESET_PC;
        lastMis = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge I_clk);
        #3;
        checkResetState();

        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0040);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0042);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0087);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        doReset();
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = $urandom();
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 19) == 0, tgt);
            if (i % 500 == 250) doReset();
        end

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge I_clk);
        #5;
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
